// File: rtl/e203_wbck_pkg.sv
// Shared constants for the EXU write-back arbiter.
// Arbitration mode encodings and deny-counter sizing.
package e203_wbck_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  localparam int CNT_W = 4;

endpackage

// File: rtl/e203_wbck_rr_sel.sv
// Rotating-priority one-hot selector.
// Search begins at i_start and wraps NSRC-1 -> 0.
module e203_wbck_rr_sel #(
  parameter int NSRC  = 3,
  parameter int PTR_W = 2
) (
  input  logic [NSRC-1:0]  i_req,
  input  logic [PTR_W-1:0] i_start,
  output logic [NSRC-1:0]  o_gnt
);

  localparam int SW = PTR_W + 1;

  logic [SW-1:0]    w_sum;
  logic [PTR_W-1:0] w_idx;
  logic             w_found;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < NSRC; k++) begin
      w_sum = SW'(i_start) + SW'(k);
      if (w_sum >= SW'(NSRC)) w_sum = w_sum - SW'(NSRC);
      w_idx = w_sum[PTR_W-1:0];
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/e203_exu_wbck_arb.sv
// Write-back arbiter: NSRC sources into one registered
// integer regfile write port, fixed+anti-starve or round-robin.
module e203_exu_wbck_arb
  import e203_wbck_pkg::*;
#(
  parameter int NSRC       = 3,
  parameter int XLEN       = 32,
  parameter int RFIDX_W    = 5,
  parameter int ARB_MODE   = 0,
  parameter int STARVE_LIM = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NSRC-1:0]         src_valid,
  output logic [NSRC-1:0]         src_ready,
  input  logic [NSRC*XLEN-1:0]    src_wdat,
  input  logic [NSRC*RFIDX_W-1:0] src_rdidx,
  input  logic [NSRC-1:0]         src_rdfpu,
  output logic                    rf_wbck_o_ena,
  output logic [XLEN-1:0]         rf_wbck_o_wdat,
  output logic [RFIDX_W-1:0]      rf_wbck_o_rdidx,
  input  logic                    rf_wbck_o_ready
);

  localparam int PTR_W = $clog2(NSRC);
  localparam bit IS_RR = (ARB_MODE == int'(ARB_RR));
  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

  logic                        r_out_vld;
  logic [XLEN-1:0]             r_wdat;
  logic [RFIDX_W-1:0]          r_rdidx;
  logic [PTR_W-1:0]            r_rr_ptr;
  logic [NSRC-1:0][CNT_W-1:0]  r_cnt;

  logic              w_drain;
  logic              w_allow;
  logic [NSRC-1:0]   w_starve;
  logic [NSRC-1:0]   w_req;
  logic [PTR_W-1:0]  w_start;
  logic [NSRC-1:0]   w_sel;
  logic [NSRC-1:0]   w_gnt;
  logic              w_any;
  logic              w_fpu;
  logic [XLEN-1:0]   w_wdat;
  logic [RFIDX_W-1:0] w_rdidx;
  logic [PTR_W-1:0]  w_gidx;
  logic [PTR_W-1:0]  w_ptr_nxt;

  assign w_drain = r_out_vld & rf_wbck_o_ready;
  assign w_allow = ~r_out_vld | w_drain;

  always_comb begin
    w_starve = '0;
    for (int i = 0; i < NSRC; i++)
      w_starve[i] = src_valid[i] & (r_cnt[i] >= LIM);
  end

  // A starved source masks all others; the selector then
  // resolves ties among starved sources by lowest index.
  assign w_req   = (!IS_RR && |w_starve) ? w_starve : src_valid;
  assign w_start = IS_RR ? r_rr_ptr : '0;

  e203_wbck_rr_sel #(
    .NSRC  (NSRC),
    .PTR_W (PTR_W)
  ) u_sel (
    .i_req   (w_req),
    .i_start (w_start),
    .o_gnt   (w_sel)
  );

  assign w_gnt     = (w_allow && !rst) ? w_sel : '0;
  assign w_any     = |w_gnt;
  assign src_ready = w_gnt;

  always_comb begin
    w_fpu   = 1'b0;
    w_wdat  = '0;
    w_rdidx = '0;
    w_gidx  = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (w_gnt[i]) begin
        w_fpu   = src_rdfpu[i];
        w_wdat  = src_wdat[i*XLEN +: XLEN];
        w_rdidx = src_rdidx[i*RFIDX_W +: RFIDX_W];
        w_gidx  = PTR_W'(i);
      end
    end
  end

  assign w_ptr_nxt = (w_gidx == PTR_W'(NSRC-1)) ?
                     '0 : w_gidx + PTR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_vld <= 1'b0;
      r_wdat    <= '0;
      r_rdidx   <= '0;
    end else if (w_any && !w_fpu) begin
      r_out_vld <= 1'b1;
      r_wdat    <= w_wdat;
      r_rdidx   <= w_rdidx;
    end else if (w_drain) begin
      r_out_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_rr_ptr <= '0;
    else if (IS_RR && w_any)
      r_rr_ptr <= w_ptr_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (IS_RR || !src_valid[i] || w_gnt[i])
          r_cnt[i] <= '0;
        else if (w_allow && r_cnt[i] != '1)
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
      end
    end
  end

  assign rf_wbck_o_ena   = r_out_vld;
  assign rf_wbck_o_wdat  = r_wdat;
  assign rf_wbck_o_rdidx = r_rdidx;

endmodule

// File: tb/tb_e203_exu_wbck_arb.sv
// Directed bench: fixed-priority and round-robin instances
// share one stimulus stream; expectations are hand-derived.
module tb_e203_exu_wbck_arb;

  localparam int NSRC = 3;
  localparam int XLEN = 32;
  localparam int RW   = 5;

  logic                 clk;
  logic                 rst;
  logic [NSRC-1:0]      src_valid;
  logic [NSRC*XLEN-1:0] src_wdat;
  logic [NSRC*RW-1:0]   src_rdidx;
  logic [NSRC-1:0]      src_rdfpu;
  logic                 ready;

  logic [NSRC-1:0] fx_rdy, rr_rdy;
  logic            fx_ena, rr_ena;
  logic [XLEN-1:0] fx_wdat, rr_wdat;
  logic [RW-1:0]   fx_idx, rr_idx;

  int n_chk  = 0;
  int n_fail = 0;

  e203_exu_wbck_arb #(.NSRC(NSRC), .ARB_MODE(0), .STARVE_LIM(4)) u_fix (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_ready(fx_rdy),
    .src_wdat(src_wdat), .src_rdidx(src_rdidx), .src_rdfpu(src_rdfpu),
    .rf_wbck_o_ena(fx_ena), .rf_wbck_o_wdat(fx_wdat),
    .rf_wbck_o_rdidx(fx_idx), .rf_wbck_o_ready(ready)
  );

  e203_exu_wbck_arb #(.NSRC(NSRC), .ARB_MODE(1), .STARVE_LIM(4)) u_rr (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_ready(rr_rdy),
    .src_wdat(src_wdat), .src_rdidx(src_rdidx), .src_rdfpu(src_rdfpu),
    .rf_wbck_o_ena(rr_ena), .rf_wbck_o_wdat(rr_wdat),
    .rf_wbck_o_rdidx(rr_idx), .rf_wbck_o_ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int i, input logic [31:0] d,
                         input logic [4:0] r);
    src_wdat[i*XLEN +: XLEN] = d;
    src_rdidx[i*RW +: RW]    = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] fx_c [6] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b100};

  initial begin
    rst       = 1'b1;
    ready     = 1'b1;
    src_valid = 3'b111;
    src_wdat  = '0;
    src_rdidx = '0;
    src_rdfpu = '0;
    #2;
    chk("rst_fx_rdy", fx_rdy, 0);
    chk("rst_rr_rdy", rr_rdy, 0);
    chk("rst_fx_ena", fx_ena, 0);
    chk("rst_rr_ena", rr_ena, 0);
    #10;
    rst       = 1'b0;
    src_valid = '0;

    // single source back-to-back
    for (int k = 0; k < 4; k++) begin
      src_valid = 3'b001;
      set_src(0, 32'h100 + k, 5'(k));
      #1;
      chk($sformatf("A_fx_rdy%0d", k), fx_rdy, 3'b001);
      chk($sformatf("A_rr_rdy%0d", k), rr_rdy, 3'b001);
      step();
      chk($sformatf("A_fx_ena%0d", k), fx_ena, 1);
      chk($sformatf("A_fx_wdat%0d", k), fx_wdat, 32'h100 + k);
      chk($sformatf("A_fx_idx%0d", k), fx_idx, k);
      chk($sformatf("A_rr_wdat%0d", k), rr_wdat, 32'h100 + k);
    end
    src_valid = '0;
    #1;
    step();
    chk("A_fx_drain", fx_ena, 0);
    chk("A_rr_drain", rr_ena, 0);

    // starvation override in fixed mode; rr alternates
    set_src(0, 32'hA0, 5'd1);
    set_src(2, 32'hA2, 5'd3);
    src_valid = 3'b101;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk($sformatf("B_fx_gnt%0d", c), fx_rdy, (c % 5 == 4) ? 3'b100 : 3'b001);
      chk($sformatf("B_rr_gnt%0d", c), rr_rdy, (c % 2 == 0) ? 3'b100 : 3'b001);
      step();
      chk($sformatf("B_fx_wdat%0d", c), fx_wdat, (c % 5 == 4) ? 32'hA2 : 32'hA0);
    end
    src_valid = '0;
    step();

    // stall holds the output register
    set_src(1, 32'hDEADBEEF, 5'd5);
    src_valid = 3'b010;
    #1;
    step();
    chk("D_fx_load", fx_ena, 1);
    chk("D_fx_idx", fx_idx, 5);
    ready     = 1'b0;
    src_valid = 3'b111;
    set_src(1, 32'h55, 5'd9);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("D_fx_rdy%0d", c), fx_rdy, 0);
      chk($sformatf("D_rr_rdy%0d", c), rr_rdy, 0);
      step();
      chk($sformatf("D_fx_ena%0d", c), fx_ena, 1);
      chk($sformatf("D_fx_wdat%0d", c), fx_wdat, 32'hDEADBEEF);
      chk($sformatf("D_fx_idx%0d", c), fx_idx, 5);
    end
    ready     = 1'b1;
    src_valid = '0;
    #1;
    chk("D_fx_ena_c4", fx_ena, 1);
    step();
    chk("D_fx_drained", fx_ena, 0);

    // reset in the middle of a stall
    set_src(0, 32'hE0, 5'd2);
    set_src(2, 32'hE2, 5'd4);
    src_valid = 3'b101;
    step();
    step();
    chk("E_fx_cnt2", u_fix.r_cnt[2], 2);
    chk("E_rr_ptr", u_rr.r_rr_ptr, 1);
    ready = 1'b0;
    step();
    chk("E_fx_ena", fx_ena, 1);
    chk("E_fx_wdat", fx_wdat, 32'hE0);
    chk("E_rr_wdat", rr_wdat, 32'hE0);
    rst = 1'b1;
    #1;
    chk("E_fx_ena_rst", fx_ena, 0);
    chk("E_rr_ena_rst", rr_ena, 0);
    chk("E_fx_rdy_rst", fx_rdy, 0);
    chk("E_rr_rdy_rst", rr_rdy, 0);
    chk("E_fx_cnt_rst", u_fix.r_cnt, 0);
    chk("E_rr_ptr_rst", u_rr.r_rr_ptr, 0);
    #1;
    rst       = 1'b0;
    src_valid = '0;
    ready     = 1'b1;
    step();
    chk("E_fx_nowrite", fx_ena, 0);
    chk("E_rr_nowrite", rr_ena, 0);

    // round-robin order with all sources valid
    for (int i = 0; i < 3; i++) set_src(i, 32'hC0 + i, 5'(10 + i));
    src_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("C_rr_gnt%0d", c), rr_rdy, 3'b001 << (c % 3));
      chk($sformatf("C_fx_gnt%0d", c), fx_rdy, fx_c[c]);
      step();
      chk($sformatf("C_rr_wdat%0d", c), rr_wdat, 32'hC0 + (c % 3));
    end
    src_valid = '0;
    step();
    chk("C_rr_ptr", u_rr.r_rr_ptr, 0);
    chk("C_rr_ena", rr_ena, 0);

    // FPU destination: acknowledged, never written
    src_rdfpu = 3'b010;
    set_src(0, 32'hF0, 5'd1);
    set_src(1, 32'hF1, 5'd2);
    src_valid = 3'b010;
    #1;
    chk("F_fx_rdy", fx_rdy, 3'b010);
    chk("F_rr_rdy", rr_rdy, 3'b010);
    step();
    chk("F_fx_ena", fx_ena, 0);
    chk("F_rr_ena", rr_ena, 0);
    src_valid = 3'b001;
    #1;
    step();
    chk("F_fx_int", fx_ena, 1);
    src_valid = 3'b010;
    #1;
    chk("F_fx_rdy2", fx_rdy, 3'b010);
    step();
    chk("F_fx_ena2", fx_ena, 0);
    chk("F_fx_wdat2", fx_wdat, 32'hF0);
    src_valid = '0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
